// File: rtl/mux_shift_pkg.sv
// Shared types for the multi-mode shift register: operation encoding and FSM states.
package mux_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_ROL  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/mux_shift_step.sv
// Single-step combinational shifter: next register value and the bit pushed out.
module mux_shift_step
    import mux_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  mode_t            mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] nxt,
    output logic             shifted
);

    always_comb begin
        nxt     = cur;
        shifted = 1'b0;
        case (mode)
            MODE_SHL: begin
                nxt     = {cur[WIDTH-2:0], serial_in};
                shifted = cur[WIDTH-1];
            end
            MODE_SHR: begin
                nxt     = {serial_in, cur[WIDTH-1:1]};
                shifted = cur[0];
            end
            MODE_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                shifted = cur[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mux_shift_reg.sv
// Multi-mode shift register: parallel load, or shift/rotate by a clamped count,
// one bit per cycle under a small IDLE/SHIFT/DONE controller.
module mux_shift_reg
    import mux_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    // Count must be able to hold WIDTH itself, independent of AMT_W.
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_next;
    mode_t              op_mode, op_mode_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [CNT_W-1:0]   amt_clamped;
    logic [WIDTH-1:0]   out_next;
    logic               serial_out_next;
    logic [WIDTH-1:0]   step_out;
    logic               step_bit;

    mux_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur      (out),
        .mode     (op_mode),
        .serial_in(serial_in),
        .nxt      (step_out),
        .shifted  (step_bit)
    );

    always_comb begin
        if (32'(amount) > 32'(WIDTH)) amt_clamped = CNT_W'(WIDTH);
        else                          amt_clamped = CNT_W'(amount);
    end

    always_comb begin
        state_next      = state;
        op_mode_next    = op_mode;
        count_next      = count;
        out_next        = out;
        serial_out_next = serial_out;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mode_t'(mode) == MODE_LOAD) begin
                        out_next   = data;
                        state_next = ST_DONE;
                    end else begin
                        op_mode_next = mode_t'(mode);
                        count_next   = amt_clamped;
                        state_next   = (amt_clamped == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                out_next        = step_out;
                serial_out_next = step_bit;
                count_next      = count - CNT_W'(1);
                // Guarding with <= 1 keeps a corrupted zero count from spinning forever.
                if (count <= CNT_W'(1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_mode    <= MODE_LOAD;
            count      <= '0;
            out        <= '0;
            serial_out <= 1'b0;
        end else begin
            state      <= state_next;
            op_mode    <= op_mode_next;
            count      <= count_next;
            out        <= out_next;
            serial_out <= serial_out_next;
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: doc/mux_shift_reg.md
MUX_SHIFT_REG -- requirements
Module: mux_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal values are 2 or more.
REQ-002 The block SHALL have parameter AMT_W, default $clog2(WIDTH)+1, giving the width of the shift-amount port.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: requests an operation.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 LOAD, 01 SHL (shift left), 10 SHR (shift right), 11 ROL (rotate left).
REQ-007 The block SHALL have port data, input, WIDTH bits: the parallel load value.
REQ-008 The block SHALL have port amount, input, AMT_W bits: the shift/rotate count.
REQ-009 The block SHALL have port serial_in, input, 1 bit: the fill bit for SHL/SHR.
REQ-010 The block SHALL have port out, output, WIDTH bits: the registered contents.
REQ-011 The block SHALL have port serial_out, output, 1 bit, registered: the bit most recently shifted or rotated out.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE; busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state.
REQ-015 start SHALL be sampled only in IDLE; start in SHIFT or DONE SHALL be ignored with no effect on out, mode or count.
REQ-016 IDLE with start and mode LOAD SHALL set out = data at that edge and go to DONE.
REQ-017 IDLE with start and a shift mode SHALL latch mode, set count = min(amount, WIDTH) and go to SHIFT, or to DONE with out unchanged if that count is 0.
REQ-018 Each edge in SHIFT SHALL perform one step, then decrement count, and go to DONE on the step that takes count from 1 to 0.
REQ-019 SHL step: out = {out[WIDTH-2:0], serial_in}, with serial_out = old out[WIDTH-1].
REQ-020 SHR step: out = {serial_in, out[WIDTH-1:1]}, with serial_out = old out[0].
REQ-021 ROL step: out = {out[WIDTH-2:0], out[WIDTH-1]}, with serial_out = old out[WIDTH-1].
REQ-022 Latency SHALL be: done high exactly N+1 cycles after the accept edge for shift count N ≥ 1, and 1 cycle after for LOAD or N = 0; busy SHALL be high for exactly N cycles.
REQ-023 DONE SHALL always return to IDLE on the next edge; back-to-back operations therefore need at least one IDLE cycle between them.
REQ-024 amount > WIDTH SHALL be clamped to WIDTH (SHL/SHR give an all-serial_in fill; ROL gives identity).
REQ-025 serial_in SHALL be sampled at every step edge, not latched at accept.
REQ-026 out and serial_out SHALL hold their values in IDLE and DONE.

Reset
REQ-027 reset_n low SHALL immediately set out = 0, serial_out = 0, count = 0 and state IDLE, giving busy = 0 and done = 0, including when asserted mid-SHIFT.
REQ-028 The first accepted start after reset_n deasserts SHALL be on an edge where reset_n is high.

Structure
REQ-029 Package mux_shift_pkg SHALL hold the mode encoding (LOAD/SHL/SHR/ROL) and the FSM state typedef.
REQ-030 One combinational sub-module, mux_shift_step, SHALL compute the single-step next out and serial_out from (out, mode, serial_in); the top level holds the FSM, count and registers.

Verification (WIDTH=8)
REQ-031 Assert reset_n low during a SHL by 5, two cycles in -> out=0x00, busy=0, done=0 immediately; after release, IDLE.
REQ-032 LOAD data=0xA5 -> out=0xA5 after the accept edge, done high for exactly the next cycle, busy never high.
REQ-033 From 0xA5, SHL amount=3, serial_in=1 -> busy 3 cycles, intermediate out 0x4B, 0x97, then 0x2F, serial_out=1, done on cycle 4.
REQ-034 From 0x81, ROL amount=1 -> out=0x03, serial_out=1; from 0x81, ROL amount=12 -> busy 8 cycles, out=0x81.
REQ-035 SHR amount=0 from 0x3C -> done next cycle, out=0x3C, busy never high; SHR amount=2, serial_in=0 from 0x3C -> out=0x0F, serial_out=0.
REQ-036 start with LOAD data=0xFF while busy and while done -> ignored; the shift completes with the expected value and out ≠ 0xFF.
